// File: rtl/osc_sample_packer_if.sv
// osc_sample_packer_if: write-side handshake between the sample packer and
// the capture write FIFO.
//   wr_data  packed word toward the FIFO (W bits)
//   wr_en    write request, driven by the packer
//   wr_vld   FIFO not full; a write happens when wr_en & wr_vld
// Modports: master = packer side, slave = FIFO side.
interface osc_sample_packer_if #(
   parameter int unsigned W = 32
);
   logic [W-1:0] wr_data;
   logic         wr_en;
   logic         wr_vld;

   modport master (output wr_data, output wr_en, input wr_vld);
   modport slave  (input wr_data, input wr_en, output wr_vld);
endinterface

// File: rtl/osc_sample_packer.sv
// osc_sample_packer: packs PACK_N ADC samples of SAMPLE_W bits into one FIFO
// word and runs a start-to-done capture of cap_len words. One packed word is
// held while the FIFO is full; words formed while the hold register is still
// occupied are dropped and counted in ovf_cnt.
// Ports:
//   clk, rst_n      sample clock, asynchronous active-low reset
//   start, cap_len  capture request and its length in words
//   abort           stops the capture at the next edge, highest priority
//   smp_data/vld    ADC sample stream, no backpressure
//   wr_if           FIFO write handshake (wr_data / wr_en / wr_vld)
//   busy, done      capture in progress / one-cycle normal completion pulse
//   ovf_cnt         saturating count of dropped words
module osc_sample_packer #(
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned PACK_N   = 4,
   parameter int unsigned LEN_W    = 16,
   parameter int unsigned OVF_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [LEN_W-1:0]    cap_len,
   input  logic [SAMPLE_W-1:0] smp_data,
   input  logic                smp_vld,
   osc_sample_packer_if.master wr_if,
   output logic                busy,
   output logic                done,
   output logic [OVF_W-1:0]    ovf_cnt
);
   localparam int unsigned WORD_W = SAMPLE_W * PACK_N;
   localparam int unsigned IDX_W  = (PACK_N > 1) ? $clog2(PACK_N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_N - 1);

   typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_FIN} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    wcnt_q, wcnt_d;
   logic [OVF_W-1:0]    ovf_q, ovf_d;
   logic [WORD_W-1:0]   word_fill;
   logic                wr_acc;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      len_d      = len_q;
      wcnt_d     = wcnt_q;
      ovf_d      = ovf_q;

      // Partial word with the current sample dropped into its lane.
      word_fill = word_q;
      for (int unsigned i = 0; i < PACK_N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            word_fill[i*SAMPLE_W +: SAMPLE_W] = smp_data;
         end
      end

      wr_acc = hold_vld_q & wr_if.wr_vld;
      if (wr_acc) begin
         hold_vld_d = 1'b0;
      end

      if (abort) begin
         state_d    = S_IDLE;
         hold_vld_d = 1'b0;
         hold_d     = '0;
         idx_d      = '0;
         word_d     = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_d   = cap_len;
                  ovf_d   = '0;
                  idx_d   = '0;
                  wcnt_d  = '0;
                  word_d  = '0;
                  state_d = (cap_len == '0) ? S_FIN : S_PACK;
               end
            end
            S_PACK: begin
               if (smp_vld) begin
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     word_d = '0;
                     // A word leaving the hold register this cycle frees it
                     // for the newly formed word at the same edge.
                     if (!hold_vld_q || wr_acc) begin
                        hold_d     = word_fill;
                        hold_vld_d = 1'b1;
                        wcnt_d     = wcnt_q + 1'b1;
                        if (wcnt_d == len_q) begin
                           state_d = S_DRAIN;
                        end
                     end else if (ovf_q != '1) begin
                        ovf_d = ovf_q + 1'b1;
                     end
                  end else begin
                     idx_d  = idx_q + 1'b1;
                     word_d = word_fill;
                  end
               end
            end
            S_DRAIN: begin
               if (!hold_vld_q) begin
                  state_d = S_FIN;
               end
            end
            S_FIN: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         word_q     <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         len_q      <= '0;
         wcnt_q     <= '0;
         ovf_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         len_q      <= len_d;
         wcnt_q     <= wcnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign wr_if.wr_en   = hold_vld_q;
   assign wr_if.wr_data = hold_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FIN);
   assign ovf_cnt       = ovf_q;
endmodule

// File: tb/tb_osc_sample_packer.sv
// tb_osc_sample_packer: directed bench for osc_sample_packer. The default
// instance (PACK_N=4) covers packing, backpressure, overflow, abort and edge
// cases; a second instance with PACK_N=1 covers back-to-back loading.
// Expected FIFO words are queued as samples are driven and popped on writes.
module tb_osc_sample_packer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, smp_vld;
   logic [15:0] cap_len;
   logic [7:0]  smp_data;
   logic        busy, done;
   logic [15:0] ovf_cnt;

   logic        start1, abort1, smp_vld1;
   logic [15:0] cap_len1;
   logic [7:0]  smp_data1;
   logic        busy1, done1;
   logic [15:0] ovf_cnt1;

   int checks = 0;
   int errors = 0;
   int writes = 0;
   int writes1 = 0;
   logic [31:0] q[$];
   logic [7:0]  q1[$];

   osc_sample_packer_if #(.W(32)) wif ();
   osc_sample_packer_if #(.W(8))  wif1 ();

   osc_sample_packer #(.SAMPLE_W(8), .PACK_N(4), .LEN_W(16), .OVF_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cap_len(cap_len),
      .smp_data(smp_data), .smp_vld(smp_vld), .wr_if(wif.master),
      .busy(busy), .done(done), .ovf_cnt(ovf_cnt));

   osc_sample_packer #(.SAMPLE_W(8), .PACK_N(1), .LEN_W(16), .OVF_W(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .cap_len(cap_len1),
      .smp_data(smp_data1), .smp_vld(smp_vld1), .wr_if(wif1.master),
      .busy(busy1), .done(done1), .ovf_cnt(ovf_cnt1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [7:0] d);
      smp_data = d;
      smp_vld  = 1'b1;
      tick();
   endtask

   task automatic do_start(input logic [15:0] len);
      cap_len = len;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Scoreboard: inputs are stable at the falling edge, so a write seen here
   // happens at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && wif.wr_en && wif.wr_vld) begin
         writes++;
         chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) chk("wr_data", 64'(wif.wr_data), 64'(q.pop_front()));
      end
      if (rst_n && wif1.wr_en && wif1.wr_vld) begin
         writes1++;
         chk("sb1_nonempty", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) chk("wr_data1", 64'(wif1.wr_data), 64'(q1.pop_front()));
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; smp_vld = 1'b0;
      cap_len = '0; smp_data = '0; wif.wr_vld = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; smp_vld1 = 1'b0;
      cap_len1 = '0; smp_data1 = '0; wif1.wr_vld = 1'b0;
      tick(); tick();
      chk("rst_wr_en", 64'(wif.wr_en), 64'd0);
      chk("rst_wr_data", 64'(wif.wr_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic pack, cap_len=2, FIFO always ready
      wif.wr_vld = 1'b1;
      do_start(16'd2);
      chk("t1_busy", 64'(busy), 64'd1);
      q.push_back(32'h44332211);
      q.push_back(32'h88776655);
      for (int i = 1; i <= 8; i++) begin
         sample(8'(i * 8'h11));
         if (i == 4) begin
            chk("t1_wr_en_lat", 64'(wif.wr_en), 64'd1);
            chk("t1_word1", 64'(wif.wr_data), 64'h44332211);
         end
      end
      smp_vld = 1'b0;
      chk("t1_wr_en2", 64'(wif.wr_en), 64'd1);
      tick();
      chk("t1_wr_en_off", 64'(wif.wr_en), 64'd0);
      chk("t1_no_done_yet", 64'(done), 64'd0);
      tick();
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_busy_fin", 64'(busy), 64'd1);
      tick();
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_busy_off", 64'(busy), 64'd0);
      chk("t1_ovf", 64'(ovf_cnt), 64'd0);

      // Backpressure hold
      wif.wr_vld = 1'b0;
      do_start(16'd1);
      q.push_back(32'h44332211);
      for (int i = 1; i <= 4; i++) sample(8'(i * 8'h11));
      smp_vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("t2_hold_en", 64'(wif.wr_en), 64'd1);
         chk("t2_hold_data", 64'(wif.wr_data), 64'h44332211);
         tick();
      end
      wif.wr_vld = 1'b1;
      tick();
      chk("t2_wr_en_off", 64'(wif.wr_en), 64'd0);
      tick();
      chk("t2_done", 64'(done), 64'd1);
      tick();

      // Overflow: two words dropped while the FIFO is full
      wif.wr_vld = 1'b0;
      do_start(16'd3);
      q.push_back(32'h04030201);
      for (int i = 1; i <= 12; i++) sample(8'(i));
      smp_vld = 1'b0;
      chk("t3_ovf", 64'(ovf_cnt), 64'd2);
      chk("t3_busy", 64'(busy), 64'd1);
      chk("t3_hold", 64'(wif.wr_data), 64'h04030201);
      wif.wr_vld = 1'b1;
      q.push_back(32'h100F0E0D);
      q.push_back(32'h14131211);
      for (int i = 13; i <= 20; i++) sample(8'(i));
      smp_vld = 1'b0;
      tick();
      chk("t3_no_done", 64'(done), 64'd0);
      tick();
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_ovf_kept", 64'(ovf_cnt), 64'd2);
      tick();
      chk("t3_busy_off", 64'(busy), 64'd0);

      // Simultaneous accept and form on the PACK_N=1 instance
      wif1.wr_vld = 1'b1;
      cap_len1 = 16'd5;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp_data1 = 8'(8'hA0 + i);
         smp_vld1  = 1'b1;
         q1.push_back(8'(8'hA0 + i));
         tick();
         chk("t4_wr_en_cont", 64'(wif1.wr_en), 64'd1);
      end
      smp_vld1 = 1'b0;
      tick();
      chk("t4_wr_en_off", 64'(wif1.wr_en), 64'd0);
      tick();
      chk("t4_done", 64'(done1), 64'd1);
      chk("t4_ovf", 64'(ovf_cnt1), 64'd0);
      tick();

      // Abort with a pending word and a partial word
      wif.wr_vld = 1'b0;
      do_start(16'd3);
      for (int i = 1; i <= 6; i++) sample(8'(8'h20 + i));
      smp_vld = 1'b0;
      chk("t5_pending", 64'(wif.wr_en), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_wr_en", 64'(wif.wr_en), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_no_done", 64'(done), 64'd0);
      tick();
      chk("t5_no_done2", 64'(done), 64'd0);
      wif.wr_vld = 1'b1;
      do_start(16'd1);
      q.push_back(32'h34333231);
      for (int i = 1; i <= 4; i++) sample(8'(8'h30 + i));
      smp_vld = 1'b0;
      chk("t5_lane0", 64'(wif.wr_data), 64'h34333231);
      tick();
      tick();
      chk("t5_done", 64'(done), 64'd1);
      tick();

      // cap_len=0
      do_start(16'd0);
      chk("t6_zero_done", 64'(done), 64'd1);
      chk("t6_zero_wr_en", 64'(wif.wr_en), 64'd0);
      tick();
      chk("t6_zero_idle", 64'(busy), 64'd0);

      // start while busy is ignored
      do_start(16'd1);
      do_start(16'd5);
      q.push_back(32'h54535251);
      for (int i = 1; i <= 4; i++) sample(8'(8'h50 + i));
      smp_vld = 1'b0;
      tick();
      tick();
      chk("t6_busy_start_done", 64'(done), 64'd1);
      tick();

      // Asynchronous reset mid-capture
      wif.wr_vld = 1'b0;
      do_start(16'd2);
      for (int i = 1; i <= 4; i++) sample(8'(8'h60 + i));
      smp_vld = 1'b0;
      chk("t7_pre_wr_en", 64'(wif.wr_en), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_wr_en", 64'(wif.wr_en), 64'd0);
      chk("t7_wr_data", 64'(wif.wr_data), 64'd0);
      chk("t7_busy", 64'(busy), 64'd0);
      chk("t7_done", 64'(done), 64'd0);
      chk("t7_ovf", 64'(ovf_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      chk("sb_empty", 64'(q.size()), 64'd0);
      chk("sb1_empty", 64'(q1.size()), 64'd0);
      chk("write_count", 64'(writes), 64'd8);
      chk("write_count1", 64'(writes1), 64'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
